// File: rtl/background_writer.sv
`default_nettype none
// ============================================================================
//  Module   : background_writer
//  Purpose  : Write side of the background tile RAM. It accepts single-cell
//             writes (col,row,bg) and whole-background fill commands, and
//             drives the 14-bit RAM write port. Address = col + row*COLS +
//             bg*COLS*ROWS, which matches the display read side.
//  Revision : 1.0  initial release
// ============================================================================
module background_writer #(
  parameter int DATA_W = 8,
  parameter int COLS   = 64,
  parameter int ROWS   = 48,
  parameter int NUM_BG = 5
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic              cmd_fill_i,
  input  logic [5:0]        cmd_col_i,
  input  logic [5:0]        cmd_row_i,
  input  logic [4:0]        cmd_bg_i,
  input  logic [DATA_W-1:0] cmd_data_i,
  output logic              wren_o,
  output logic [13:0]       wr_addr_o,
  output logic [DATA_W-1:0] wr_data_o,
  output logic              fill_done_o,
  output logic              cmd_err_o
);

  // Tiles per background, fill counter width and address arithmetic width.
  // The address sum is carried one bit wider than the RAM address so that an
  // out-of-range result can be detected instead of silently wrapping.
  localparam int TILES  = COLS * ROWS;
  localparam int CNT_W  = $clog2(TILES + 1);
  localparam int ADDR_W = 14;
  localparam int CALC_W = ADDR_W + 1;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_e;

  state_e              state_q;
  logic                cmd_ready_q;
  logic                wren_q;
  logic [ADDR_W-1:0]   wr_addr_q;
  logic [DATA_W-1:0]   wr_data_q;
  logic                fill_done_q;
  logic                cmd_err_q;
  logic [CNT_W-1:0]    fill_cnt_q;

  logic [CALC_W-1:0]   fill_base_d;
  logic [CALC_W-1:0]   cell_addr_d;
  logic                fill_bad_d;
  logic                cell_bad_d;
  logic                accept_d;

  // Candidate addresses for the command currently on the inputs.
  assign fill_base_d = CALC_W'(cmd_bg_i) * CALC_W'(TILES);
  assign cell_addr_d = CALC_W'(cmd_col_i)
                     + CALC_W'(cmd_row_i) * CALC_W'(COLS)
                     + fill_base_d;

  // A fill only depends on the background index; a cell write also needs a
  // legal row. The top address bit can only be set by illegal arguments.
  assign fill_bad_d = (cmd_bg_i >= 5'(NUM_BG)) || fill_base_d[CALC_W-1];
  assign cell_bad_d = (cmd_row_i >= 6'(ROWS)) || (cmd_bg_i >= 5'(NUM_BG))
                    || cell_addr_d[CALC_W-1];

  assign accept_d = cmd_valid_i && cmd_ready_q;

  // Command FSM: single writes pass straight through, fills stream one
  // address per cycle; all port outputs are registered here.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      cmd_ready_q <= 1'b0;
      wren_q      <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      fill_done_q <= 1'b0;
      cmd_err_q   <= 1'b0;
      fill_cnt_q  <= '0;
    end else begin
      wren_q      <= 1'b0;
      fill_done_q <= 1'b0;
      cmd_err_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          cmd_ready_q <= 1'b1;
          if (accept_d) begin
            if (cmd_fill_i) begin
              if (fill_bad_d) begin
                cmd_err_q <= 1'b1;
              end else begin
                // First fill write (k=0) is issued right away; the counter
                // holds the number of writes issued so far.
                state_q     <= FILL;
                cmd_ready_q <= 1'b0;
                wren_q      <= 1'b1;
                wr_addr_q   <= fill_base_d[ADDR_W-1:0];
                wr_data_q   <= cmd_data_i;
                fill_cnt_q  <= CNT_W'(1);
              end
            end else if (cell_bad_d) begin
              cmd_err_q <= 1'b1;
            end else begin
              wren_q    <= 1'b1;
              wr_addr_q <= cell_addr_d[ADDR_W-1:0];
              wr_data_q <= cmd_data_i;
            end
          end
        end
        FILL: begin
          if (fill_cnt_q == CNT_W'(TILES)) begin
            // Last write was shown in the previous cycle; reopen for commands.
            state_q     <= IDLE;
            cmd_ready_q <= 1'b1;
            fill_cnt_q  <= '0;
          end else begin
            wren_q      <= 1'b1;
            wr_addr_q   <= wr_addr_q + ADDR_W'(1);
            fill_done_q <= (fill_cnt_q == CNT_W'(TILES - 1));
            fill_cnt_q  <= fill_cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_q     <= IDLE;
          cmd_ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready_o = cmd_ready_q;
  assign wren_o      = wren_q;
  assign wr_addr_o   = wr_addr_q;
  assign wr_data_o   = wr_data_q;
  assign fill_done_o = fill_done_q;
  assign cmd_err_o   = cmd_err_q;

endmodule
`default_nettype wire
